// File: rtl/mec_pkg.sv
// Shared constants and edge-qualification helper for the multi-channel edge capturer.
package mec_pkg;

  localparam int unsigned MAX_CHANNELS = 32;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // True when a level flip away from old_level is an edge the mode wants reported.
  function automatic logic edge_hit(input logic [1:0] mode, input logic old_level);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = ~old_level;
      EDGE_FALL: hit = old_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/multi_edge_capturer_edge_channel.sv
// One capture channel: synchroniser, optional debounce, edge qualify, sticky pending/overrun.
module edge_channel
  import mec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       i_raw,
  input  logic [1:0] i_mode,
  input  logic       i_clear,
  input  logic       i_prime,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_pending,
  output logic       o_overrun
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_pending;
  logic                   r_overrun;
  logic                   w_sync;
  logic                   w_flip;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign w_flip = (w_sync != r_level);
  end else begin : g_debounce
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counts consecutive cycles the synchronised input disagrees with the accepted level.
    always_ff @(posedge sys_clk) begin
      if (sys_rst || i_prime || w_flip) r_cnt <= '0;
      else if (w_sync != r_level)       r_cnt <= r_cnt + CNT_W'(1);
      else                              r_cnt <= '0;
    end

    assign w_flip = (r_cnt == CNT_W'(DEBOUNCE_CYCLES));
  end

  // During prime the level follows the chain so a pre-reset input never looks like an edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else if (i_prime) begin
      r_level <= w_sync;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_flip && edge_hit(i_mode, r_level);
      if (w_flip) r_level <= ~r_level;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_pulse)      r_pending <= 1'b1;
      else if (i_clear) r_pending <= 1'b0;

      if (i_clear && !r_pulse)                   r_overrun <= 1'b0;
      else if (r_pulse && r_pending && !i_clear) r_overrun <= 1'b1;
    end
  end

  assign o_level   = r_level;
  assign o_pulse   = r_pulse;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/multi_edge_capturer.sv
// N-channel edge capturer: per-channel capture slices plus shared prime timer and irq.
module multi_edge_capturer
  import mec_pkg::*;
#(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [CHANNELS-1:0]   signal_in,
  input  logic [2*CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0]   irq_en,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  irq
);

  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);

  logic [PRIME_W-1:0]  r_prime_cnt;
  logic                r_irq;
  logic                w_prime;
  logic [CHANNELS-1:0] w_pending;

  // Counts down SYNC_STAGES+1 cycles after reset while the chains fill.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                   r_prime_cnt <= PRIME_W'(SYNC_STAGES + 1);
    else if (r_prime_cnt != '0)    r_prime_cnt <= r_prime_cnt - PRIME_W'(1);
  end

  assign w_prime = (r_prime_cnt != '0);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .i_raw    (signal_in[gi]),
      .i_mode   (edge_mode[2*gi +: 2]),
      .i_clear  (clear[gi]),
      .i_prime  (w_prime),
      .o_level  (level_out[gi]),
      .o_pulse  (edge_pulse[gi]),
      .o_pending(w_pending[gi]),
      .o_overrun(overrun[gi])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_irq <= 1'b0;
    else         r_irq <= |(w_pending & irq_en);
  end

  assign pending = w_pending;
  assign irq     = r_irq;

endmodule
